seq_addsub_32: RTL and testbench

SEQ_ADDSUB_32 -- requirements
Module: seq_addsub_32

---
 rtl/seq_addsub_32_pkg.sv | 17 +
 rtl/seq_addsub_32_if.sv | 36 +++
 rtl/seq_addsub_32_cla.sv | 32 +++
 rtl/seq_addsub_32.sv | 129 ++++++++++++
 tb/tb_seq_addsub_32.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_addsub_32_pkg.sv
// Shared types and constants for the nibble-serial 32-bit adder/subtractor.
package seq_addsub_32_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NIBBLE  = 4;
    localparam int unsigned NIBBLES = WIDTH / NIBBLE;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [NIBBLES-1:0][NIBBLE-1:0] nib_vec_t;

endpackage

// File: rtl/seq_addsub_32_if.sv
// Request/result bundle for seq_addsub_32; zero/ovf exist only with ADDSUB_FLAGS_EN.
interface seq_addsub_32_if;
    import seq_addsub_32_pkg::*;

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             P;
    logic             G;
    logic             busy;
    logic             done;
`ifdef ADDSUB_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    modport master (
        output start, sub, A, B,
        input  sum, cout, P, G, busy, done
`ifdef ADDSUB_FLAGS_EN
        , input zero, ovf
`endif
    );

    modport slave (
        input  start, sub, A, B,
        output sum, cout, P, G, busy, done
`ifdef ADDSUB_FLAGS_EN
        , output zero, ovf
`endif
    );

endinterface

// File: rtl/seq_addsub_32_cla.sv
// 4-bit carry-lookahead slice; p/g are the slice group propagate/generate (p uses a^b).
module cla_4bit_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       p,
    output logic       g
);

    logic [3:0] pi;
    logic [3:0] gi;
    logic [4:0] c;

    always_comb begin
        pi   = a ^ b;
        gi   = a & b;
        c[0] = cin;
        c[1] = gi[0] | (pi[0] & cin);
        c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
        c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
             | (pi[2] & pi[1] & pi[0] & cin);
        g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
        p    = &pi;
        c[4] = g | (p & cin);
        s    = pi ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/seq_addsub_32.sv
// Nibble-serial 32-bit add/subtract: one 4-bit CLA slice, eight RUN cycles per operation.
// Define ADDSUB_FLAGS_EN to add the zero and signed-overflow flag outputs.
module seq_addsub_32
    import seq_addsub_32_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    seq_addsub_32_if.slave bus
);

    state_t             state;
    state_t             state_next;
    nib_vec_t           opa;
    nib_vec_t           opb;
    nib_vec_t           sum_r;
    nib_vec_t           sum_next;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               cout_r;
    logic               p_r;
    logic               g_r;
    logic               load;
    logic               step;
    logic               last;
    logic [NIBBLE-1:0]  s_nib;
    logic               s_cout;
    logic               s_p;
    logic               s_g;

    cla_4bit_slice u_slice (
        .a    (opa[idx]),
        .b    (opb[idx]),
        .cin  (carry),
        .s    (s_nib),
        .cout (s_cout),
        .p    (s_p),
        .g    (s_g)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = (idx == IDX_W'(NIBBLES - 1));
        sum_next   = sum_r;
        sum_next[idx] = s_nib;
        case (state)
            IDLE: if (bus.start) begin
                load       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                load       = bus.start;
                state_next = bus.start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // B is stored pre-inverted for subtraction so RUN is a plain add with carry-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            cout_r <= 1'b0;
            p_r    <= 1'b0;
            g_r    <= 1'b0;
        end else if (load) begin
            opa    <= bus.A;
            opb    <= bus.B ^ {WIDTH{bus.sub}};
            carry  <= bus.sub;
            idx    <= '0;
            p_r    <= 1'b1;
            g_r    <= 1'b0;
        end else if (step) begin
            sum_r  <= sum_next;
            carry  <= s_cout;
            idx    <= idx + 1'b1;
            p_r    <= p_r & s_p;
            g_r    <= s_g | (s_p & g_r);
            if (last) cout_r <= s_cout;
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic zero_r;
    logic ovf_r;
    logic c31;

    // Carry into bit 31 recovered from the top bit's sum: s = a ^ b ^ cin.
    assign c31 = opa[idx][NIBBLE-1] ^ opb[idx][NIBBLE-1] ^ s_nib[NIBBLE-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (load) begin
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (step && last) begin
            zero_r <= (sum_next == '0);
            ovf_r  <= c31 ^ s_cout;
        end
    end

    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;
`endif

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.P    = p_r;
    assign bus.G    = g_r;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_seq_addsub_32.sv
// Self-checking bench for seq_addsub_32 against an arithmetic reference model.
module tb_seq_addsub_32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_addsub_32_if bus();

    seq_addsub_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: whole-word arithmetic on the specified rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] sm, output logic c, output logic p,
                                  output logic g, output logic z, output logic v);
        logic [31:0] be;
        logic [32:0] full;
        logic [32:0] nocin;
        be    = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, be} + {32'd0, s};
        nocin = {1'b0, a} + {1'b0, be};
        sm = full[31:0];
        c  = full[32];
        p  = ((a ^ be) == 32'hFFFF_FFFF);
        g  = nocin[32];
        z  = (sm == 32'd0);
        if (s) v = (a[31] != b[31]) && (sm[31] != a[31]);
        else   v = (a[31] == b[31]) && (sm[31] != a[31]);
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int cycles, output int busy_cyc, output bit seen);
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.sub = s;
        @(negedge clk);
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.sub = 1'($urandom);
        cycles = 1; busy_cyc = 0; seen = 1'b0;
        while (!seen && cycles <= 20) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) seen = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.sub = 1'b0; bus.A = 32'h1234_5678; bus.B = 32'h1;
        @(negedge clk); @(negedge clk);
        n_checks++; if (bus.sum !== 32'd0) begin n_fail++; $display("FAIL reset_sum got %h want 0", bus.sum); end
        n_checks++; if ({bus.cout, bus.P, bus.G} !== 3'b000) begin n_fail++; $display("FAIL reset_cpg got %b want 000", {bus.cout, bus.P, bus.G}); end
        n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done got %b want 00", {bus.busy, bus.done}); end
`ifdef ADDSUB_FLAGS_EN
        n_checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {bus.zero, bus.ovf}); end
`endif
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        int cyc; int bcyc; bit seen;
        do_op(32'd5, 32'd9, 1'b0, cyc, bcyc, seen);
        n_checks++; if (!seen || cyc != 9) begin n_fail++; $display("FAIL add_latency got %0d (seen %0d) want 9", cyc, seen); end
        n_checks++; if (bcyc != 8) begin n_fail++; $display("FAIL add_busy_cycles got %0d want 8", bcyc); end
        n_checks++; if (bus.sum !== 32'd14) begin n_fail++; $display("FAIL add_sum got %h want 0000000e", bus.sum); end
        n_checks++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL add_cout got %b want 0", bus.cout); end
        @(negedge clk);
        n_checks++; if ({bus.done, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL done_pulse_width got done=%b busy=%b want 0 0", bus.done, bus.busy); end
        n_checks++; if (bus.sum !== 32'd14) begin n_fail++; $display("FAIL sum_hold got %h want 0000000e", bus.sum); end
        @(negedge clk);
    endtask

    task automatic test_add_carry();
        int cyc; int bcyc; bit seen;
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, cyc, bcyc, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL carry_done got none want pulse"); end
        n_checks++; if (bus.sum !== 32'd0) begin n_fail++; $display("FAIL carry_sum got %h want 0", bus.sum); end
        n_checks++; if ({bus.cout, bus.P, bus.G} !== 3'b101) begin n_fail++; $display("FAIL carry_cpg got %b want 101", {bus.cout, bus.P, bus.G}); end
`ifdef ADDSUB_FLAGS_EN
        n_checks++; if ({bus.zero, bus.ovf} !== 2'b10) begin n_fail++; $display("FAIL carry_flags got %b want 10", {bus.zero, bus.ovf}); end
`endif
        @(negedge clk);
    endtask

    task automatic test_sub();
        int cyc; int bcyc; bit seen;
        do_op(32'd5, 32'd9, 1'b1, cyc, bcyc, seen);
        n_checks++; if (!seen || bus.sum !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sub_neg_sum got %h want fffffffc", bus.sum); end
        n_checks++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL sub_neg_cout got %b want 0", bus.cout); end
        @(negedge clk);
        do_op(32'd9, 32'd5, 1'b1, cyc, bcyc, seen);
        n_checks++; if (!seen || bus.sum !== 32'd4) begin n_fail++; $display("FAIL sub_pos_sum got %h want 4", bus.sum); end
        n_checks++; if (bus.cout !== 1'b1) begin n_fail++; $display("FAIL sub_pos_cout got %b want 1", bus.cout); end
        @(negedge clk);
    endtask

    task automatic test_signed_ovf();
        int cyc; int bcyc; bit seen;
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, cyc, bcyc, seen);
        n_checks++; if (!seen || bus.sum !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_sum got %h want 80000000", bus.sum); end
        n_checks++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL ovf_cout got %b want 0", bus.cout); end
`ifdef ADDSUB_FLAGS_EN
        n_checks++; if ({bus.zero, bus.ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags got %b want 01", {bus.zero, bus.ovf}); end
`endif
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int cyc; bit seen;
        bus.start = 1'b1; bus.A = 32'd1; bus.B = 32'd1; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc <= 20) begin
            if (bus.done) seen = 1'b1;
            else begin
                bus.start = (cyc == 3);
                if (cyc == 3) begin bus.A = 32'hF; bus.B = 32'hF; end
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        n_checks++; if (!seen || cyc != 9) begin n_fail++; $display("FAIL busy_restart_latency got %0d want 9", cyc); end
        n_checks++; if (bus.sum !== 32'd2) begin n_fail++; $display("FAIL busy_restart_sum got %h want 2", bus.sum); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int cyc; int bcyc; bit seen;
        bus.start = 1'b1; bus.A = 32'h1234_5678; bus.B = 32'h1111_1111; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL midrst_busy_done got %b want 00", {bus.busy, bus.done}); end
        n_checks++; if (bus.sum !== 32'd0) begin n_fail++; $display("FAIL midrst_sum got %h want 0", bus.sum); end
        @(negedge clk);
        rst = 1'b0;
        // Start on the very first edge after reset release; a stale done would shorten the latency.
        do_op(32'd11, 32'd4, 1'b0, cyc, bcyc, seen);
        n_checks++; if (!seen || cyc != 9) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 9", cyc); end
        n_checks++; if (bus.sum !== 32'd15) begin n_fail++; $display("FAIL midrst_next_sum got %h want f", bus.sum); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; int bcyc; bit seen;
        do_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, cyc, bcyc, seen);
        n_checks++; if (!seen || bus.sum !== 32'hDEAD_D000) begin n_fail++; $display("FAIL b2b_first_sum got %h want deadd000", bus.sum); end
        do_op(32'h1000_0000, 32'h0000_0001, 1'b1, cyc, bcyc, seen);
        n_checks++; if (!seen || cyc != 9) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 9", cyc); end
        n_checks++; if (bus.sum !== 32'h0FFF_FFFF || bus.cout !== 1'b1) begin n_fail++; $display("FAIL b2b_second_result got %h/%b want 0fffffff/1", bus.sum, bus.cout); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc; int bcyc; bit seen;
        logic [31:0] a; logic [31:0] b; logic s;
        logic [31:0] e_sum; logic e_c; logic e_p; logic e_g; logic e_z; logic e_v;
        for (int i = 0; i < 60; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom);
            if (i % 10 == 0) b = a;
            model(a, b, s, e_sum, e_c, e_p, e_g, e_z, e_v);
            do_op(a, b, s, cyc, bcyc, seen);
            n_checks++; if (!seen || cyc != 9 || bcyc != 8) begin n_fail++; $display("FAIL rand_timing[%0d] got cyc=%0d busy=%0d want 9 8", i, cyc, bcyc); end
            n_checks++; if (bus.sum !== e_sum || bus.cout !== e_c) begin n_fail++; $display("FAIL rand_result[%0d] %h%s%h got %h/%b want %h/%b", i, a, s ? "-" : "+", b, bus.sum, bus.cout, e_sum, e_c); end
            n_checks++; if (bus.P !== e_p || bus.G !== e_g) begin n_fail++; $display("FAIL rand_pg[%0d] got %b%b want %b%b", i, bus.P, bus.G, e_p, e_g); end
`ifdef ADDSUB_FLAGS_EN
            n_checks++; if (bus.zero !== e_z || bus.ovf !== e_v) begin n_fail++; $display("FAIL rand_flags[%0d] got %b%b want %b%b", i, bus.zero, bus.ovf, e_z, e_v); end
`endif
            if ($urandom_range(1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.sub = 1'b0; bus.A = '0; bus.B = '0;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_signed_ovf();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
